uart_rx: RTL

Receive half of the peripheral UART: deserialises the line driven by a `uart_tx` peer (1 start bit, 8 data bits LSB-first, even parity, 1 or 2 stop bits) into bytes. Output is a single-entry holding register with a valid/ready handshake to the bus-side register file or RX FIFO. It flags parity, framing and overrun errors. Bit timing is derived from the same `UART_CLK_FREQ` / `BAUD_RATE` constants as the transmitter, so both ends agree on the bit period.

---
 rtl/uart_rx_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 30 +++
 rtl/uart_rx.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: clock frequency, state encodings and bit-period helper.
package uart_rx_pkg;

  localparam int unsigned UART_CLK_FREQ = 50_000_000;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_DATA       = 3'd2,
    ST_PARITY     = 3'd3,
    ST_STOP_FIRST = 3'd4,
    ST_STOP_LAST  = 3'd5
  } uart_state_e;

  // Bit period in clocks; identical formula on the transmit side keeps both ends aligned.
  function automatic int unsigned bit_period(input int unsigned baud);
    return UART_CLK_FREQ / baud + 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line plus falling-edge detector.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic rx_sync_o,
  output logic fall_pulse_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Flops reset high so an idle line out of reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_sync_o    = sync_q;
  assign fall_pulse_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB-first, even parity, 1 or 2 stop bits,
// single-entry holding register with valid/ready and parity/frame/overrun pulses.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  input  logic       cfg_en_i,
  input  logic       cfg_stop_bits_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       err_parity_o,
  output logic       err_frame_o,
  output logic       err_overrun_o
);

  localparam int unsigned P     = bit_period(BAUD_RATE);
  localparam int unsigned H     = P / 2;
  localparam int unsigned CNT_W = $clog2(P);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(H - 1);

  uart_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic             par_q;
  logic             par_err_q;
  logic             frame_err_q;

  logic [7:0]       data_q;
  logic             valid_q;
  logic             err_parity_q;
  logic             err_frame_q;
  logic             err_overrun_q;

  logic             rx_sync;
  logic             fall_pulse;
  logic             bit_done;
  logic             half_done;
  logic             deliver;
  logic             frame_bad;

  uart_rx_sync u_sync (
    .clk          (clk),
    .rst          (rst),
    .rx_i         (rx_i),
    .rx_sync_o    (rx_sync),
    .fall_pulse_o (fall_pulse)
  );

  assign bit_done  = (cnt_q == CNT_LAST);
  assign half_done = (cnt_q == CNT_HALF);
  assign deliver   = cfg_en_i && bit_done &&
                     ((state_q == ST_STOP_FIRST && !cfg_stop_bits_i) ||
                      state_q == ST_STOP_LAST);
  // Includes the stop bit being sampled in the delivering cycle.
  assign frame_bad = frame_err_q | ~rx_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else if (!cfg_en_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (fall_pulse) begin
            state_q     <= ST_START;
            idx_q       <= '0;
            par_q       <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
          end
        end
        ST_START: begin
          if (half_done) begin
            cnt_q   <= '0;
            state_q <= rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            cnt_q   <= '0;
            shift_q <= {rx_sync, shift_q[7:1]};
            par_q   <= par_q ^ rx_sync;
            idx_q   <= idx_q + 1'b1;
            if (idx_q == 3'd7) state_q <= ST_PARITY;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_PARITY: begin
          if (bit_done) begin
            cnt_q     <= '0;
            par_err_q <= (rx_sync != par_q);
            state_q   <= ST_STOP_FIRST;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_STOP_FIRST: begin
          if (bit_done) begin
            cnt_q <= '0;
            if (!rx_sync) frame_err_q <= 1'b1;
            state_q <= cfg_stop_bits_i ? ST_STOP_LAST : ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_STOP_LAST: begin
          if (bit_done) begin
            cnt_q <= '0;
            if (!rx_sync) frame_err_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // A byte accepted in the delivery cycle frees the slot, so the new byte loads without overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q        <= 8'h00;
      valid_q       <= 1'b0;
      err_parity_q  <= 1'b0;
      err_frame_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      err_parity_q  <= 1'b0;
      err_frame_q   <= 1'b0;
      err_overrun_q <= 1'b0;
      if (deliver) begin
        if (!valid_q || rx_ready_i) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          err_overrun_q <= 1'b1;
        end
        err_parity_q <= par_err_q;
        err_frame_q  <= frame_bad;
      end else if (valid_q && rx_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_data_o     = data_q;
  assign rx_valid_o    = valid_q;
  assign err_parity_o  = err_parity_q;
  assign err_frame_o   = err_frame_q;
  assign err_overrun_o = err_overrun_q;

endmodule
